// File: rtl/spi_frame_sender_if.sv
// Buffer read port, SPI pins and frame status of the frame sender.
// The master side is the controller/buffer/slave environment; the slave side is the sender.
interface spi_frame_sender_if;
   logic       START;
   logic [5:0] LEN;
   logic [4:0] ADDR;
   logic       READ;
   logic [7:0] BYTEIN;
   logic       SCK;
   logic       MOSI;
   logic       MISO;
   logic       SS_N;
   logic [7:0] RXBYTE;
   logic       RXVALID;
   logic       BUSY;
   logic       DONE;

   modport master (
      output START, LEN, BYTEIN, MISO,
      input  ADDR, READ, SCK, MOSI, SS_N, RXBYTE, RXVALID, BUSY, DONE
   );

   modport slave (
      input  START, LEN, BYTEIN, MISO,
      output ADDR, READ, SCK, MOSI, SS_N, RXBYTE, RXVALID, BUSY, DONE
   );
endinterface

// File: rtl/spi_frame_sender.sv
// SPI mode-0 master: reads min(LEN,MAX_LEN) buffer bytes and shifts them out MSB first under one SS_N.
// Latency: 3 + 16*CLK_DIV cycles per byte plus CLK_DIV hold cycles; no backpressure, START is ignored while busy.
module spi_frame_sender #(
   parameter int CLK_DIV = 4,
   parameter int MAX_LEN = 32
) (
   input  logic                CLK,
   input  logic                RESET,
   spi_frame_sender_if.slave   bus
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT,
      LOAD,
      SHIFT_LO,
      SHIFT_HI,
      FINISH
   } state_t;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [5:0] LEN_MAX  = 6'(MAX_LEN);

   state_t     state;
   logic [5:0] len_r;
   logic [7:0] tx_sr;
   logic [7:0] rx_sr;
   logic [2:0] bit_cnt;
   logic [7:0] div_cnt;
   logic       div_last;

   assign div_last = (div_cnt == DIV_LAST);

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state       <= IDLE;
         len_r       <= '0;
         tx_sr       <= '0;
         rx_sr       <= '0;
         bit_cnt     <= '0;
         div_cnt     <= '0;
         bus.SS_N    <= 1'b1;
         bus.SCK     <= 1'b0;
         bus.MOSI    <= 1'b0;
         bus.READ    <= 1'b0;
         bus.ADDR    <= '0;
         bus.BUSY    <= 1'b0;
         bus.DONE    <= 1'b0;
         bus.RXBYTE  <= '0;
         bus.RXVALID <= 1'b0;
      end else begin
         bus.RXVALID <= 1'b0;
         bus.DONE    <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.START && (bus.LEN != 6'd0)) begin
                  state    <= FETCH;
                  bus.BUSY <= 1'b1;
                  bus.SS_N <= 1'b0;
                  bus.ADDR <= '0;
                  bus.READ <= 1'b1;
                  len_r    <= (bus.LEN > LEN_MAX) ? LEN_MAX : bus.LEN;
               end
            end
            FETCH: begin
               bus.READ <= 1'b0;
               state    <= WAIT;
            end
            // Buffer output settles for a full cycle after its READ edge.
            WAIT: state <= LOAD;
            LOAD: begin
               tx_sr    <= bus.BYTEIN;
               bus.MOSI <= bus.BYTEIN[7];
               bit_cnt  <= 3'd7;
               div_cnt  <= '0;
               state    <= SHIFT_LO;
            end
            SHIFT_LO: begin
               if (div_last) begin
                  div_cnt <= '0;
                  bus.SCK <= 1'b1;
                  rx_sr   <= {rx_sr[6:0], bus.MISO};
                  state   <= SHIFT_HI;
               end else begin
                  div_cnt <= div_cnt + 8'd1;
               end
            end
            SHIFT_HI: begin
               if (div_last) begin
                  div_cnt <= '0;
                  bus.SCK <= 1'b0;
                  if (bit_cnt != 3'd0) begin
                     bit_cnt  <= bit_cnt - 3'd1;
                     tx_sr    <= {tx_sr[6:0], 1'b0};
                     bus.MOSI <= tx_sr[6];
                     state    <= SHIFT_LO;
                  end else begin
                     bus.RXBYTE  <= rx_sr;
                     bus.RXVALID <= 1'b1;
                     if ({1'b0, bus.ADDR} == (len_r - 6'd1)) begin
                        state <= FINISH;
                     end else begin
                        bus.ADDR <= bus.ADDR + 5'd1;
                        bus.READ <= 1'b1;
                        state    <= FETCH;
                     end
                  end
               end else begin
                  div_cnt <= div_cnt + 8'd1;
               end
            end
            // SS_N hold time after the last falling SCK edge.
            FINISH: begin
               if (div_last) begin
                  div_cnt  <= '0;
                  bus.SS_N <= 1'b1;
                  bus.DONE <= 1'b1;
                  bus.BUSY <= 1'b0;
                  bus.MOSI <= 1'b0;
                  state    <= IDLE;
               end else begin
                  div_cnt <= div_cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_frame_sender.sv
// Directed bench: a CLK_DIV=2 sender for frame/reset tests and a CLK_DIV=1 sender for back-to-back frames.
module tb_spi_frame_sender;

   localparam int DIV_A = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   spi_frame_sender_if a_if ();
   spi_frame_sender_if b_if ();

   spi_frame_sender #(.CLK_DIV(DIV_A), .MAX_LEN(32)) dut_a (.CLK(clk), .RESET(reset), .bus(a_if.slave));
   spi_frame_sender #(.CLK_DIV(1),     .MAX_LEN(32)) dut_b (.CLK(clk), .RESET(reset), .bus(b_if.slave));

   logic [7:0] buf_mem [32];
   logic [7:0] sl_mem  [32];
   logic [7:0] a_byte = 8'h00;
   logic [7:0] b_byte = 8'h00;
   logic [8:0] fall_cnt = 9'd0;

   always @(posedge clk) begin
      if (a_if.READ) a_byte <= buf_mem[a_if.ADDR];
      if (b_if.READ) b_byte <= buf_mem[b_if.ADDR];
   end
   assign a_if.BYTEIN = a_byte;
   assign b_if.BYTEIN = b_byte;
   assign b_if.MISO   = 1'b0;

   // Mode-0 slave: advances to its next bit on each falling SCK, restarts when deselected.
   always @(negedge a_if.SCK or posedge a_if.SS_N) begin
      if (a_if.SS_N) fall_cnt = 9'd0;
      else           fall_cnt = fall_cnt + 9'd1;
   end
   assign a_if.MISO = sl_mem[fall_cnt[7:3]][3'd7 - fall_cnt[2:0]];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Monitor of the CLK_DIV=2 sender, sampled on the falling clock edge.
   logic [4:0] rd_q [$];
   logic       mosi_q [$];
   logic [7:0] rx_q [$];
   int  rise_cnt, done_cnt, long_n, short_n, other_n, low_run, ss_run, ss_last;
   logic busy_seen, done_at_rise;
   logic a_sck_q = 1'b0;
   logic a_ss_q  = 1'b1;

   task automatic clear_mon();
      rd_q.delete(); mosi_q.delete(); rx_q.delete();
      rise_cnt = 0; done_cnt = 0; long_n = 0; short_n = 0; other_n = 0;
      low_run = 0; ss_run = 0; ss_last = 0; busy_seen = 1'b0; done_at_rise = 1'b0;
   endtask

   always @(negedge clk) begin
      if (a_if.READ) rd_q.push_back(a_if.ADDR);
      if (!a_if.SS_N && !a_if.SCK) low_run++;
      if (a_if.SCK && !a_sck_q) begin
         mosi_q.push_back(a_if.MOSI);
         rise_cnt++;
         if (low_run == 3 + DIV_A)  long_n++;
         else if (low_run == DIV_A) short_n++;
         else                       other_n++;
         low_run = 0;
      end
      if (a_if.SS_N) low_run = 0;
      if (a_if.RXVALID) rx_q.push_back(a_if.RXBYTE);
      if (a_if.DONE) done_cnt++;
      if (a_if.BUSY) busy_seen = 1'b1;
      if (!a_if.SS_N) ss_run++;
      else if (!a_ss_q) begin
         ss_last      = ss_run;
         done_at_rise = a_if.DONE;
         ss_run       = 0;
      end
      a_sck_q = a_if.SCK;
      a_ss_q  = a_if.SS_N;
   end

   // Monitor of the CLK_DIV=1 sender.
   logic [4:0] b_rd_q [$];
   int  b_t = 0, b_lr = 0, b_per2 = 0, b_perx = 0, b_done = 0, b_hi_run = 0, b_hi_last = 0;
   logic b_rv = 1'b0;
   logic b_sck_q = 1'b0;

   always @(negedge clk) begin
      b_t++;
      if (b_if.READ) b_rd_q.push_back(b_if.ADDR);
      if (b_if.DONE) b_done++;
      if (b_if.SS_N) begin
         b_rv = 1'b0;
         b_hi_run++;
      end else begin
         if (b_hi_run != 0) b_hi_last = b_hi_run;
         b_hi_run = 0;
         if (b_if.SCK && !b_sck_q) begin
            if (b_rv) begin
               if (b_t - b_lr == 2) b_per2++;
               else                 b_perx++;
            end
            b_lr = b_t;
            b_rv = 1'b1;
         end
      end
      b_sck_q = b_if.SCK;
   end

   function automatic logic [7:0] mosi_byte(input int k);
      logic [7:0] r;
      r = 8'h00;
      for (int j = 0; j < 8; j++) r[7-j] = mosi_q[8*k+j];
      return r;
   endfunction

   function automatic logic [19:0] out_vec();
      return {a_if.SS_N, a_if.SCK, a_if.MOSI, a_if.READ, a_if.ADDR, a_if.BUSY,
              a_if.DONE, a_if.RXBYTE, a_if.RXVALID};
   endfunction

   localparam logic [19:0] RESET_VEC = {1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 8'h00, 1'b0};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_a(input logic [5:0] len);
      a_if.LEN   = len;
      a_if.START = 1'b1;
      tick();
      a_if.START = 1'b0;
   endtask

   task automatic wait_a_done(input string tag, input int target, input int budget);
      int k;
      for (k = 0; k < budget; k++) begin
         @(negedge clk);
         #1;
         if (done_cnt >= target) break;
      end
      check(tag, 32'(done_cnt >= target), 32'd1);
   endtask

   task automatic wait_b_done(input string tag, input int budget);
      int k;
      for (k = 0; k < budget; k++) begin
         @(negedge clk);
         #1;
         if (b_if.DONE) break;
      end
      check(tag, 32'(b_if.DONE), 32'd1);
   endtask

   initial begin
      int bad;
      int k;
      reset = 1'b0;
      a_if.START = 1'b0; a_if.LEN = 6'd0;
      b_if.START = 1'b0; b_if.LEN = 6'd0;
      for (int i = 0; i < 32; i++) begin
         buf_mem[i] = 8'h00;
         sl_mem[i]  = 8'h00;
      end
      clear_mon();
      repeat (3) tick();
      @(negedge clk);
      check("reset_outputs", 32'(out_vec()), 32'(RESET_VEC));
      tick();
      reset = 1'b1;
      repeat (2) tick();

      // Single byte.
      buf_mem[0] = 8'hA5;
      sl_mem[0]  = 8'h3C;
      clear_mon();
      pulse_a(6'd1);
      wait_a_done("t1_done_timeout", 1, 200);
      repeat (2) tick();
      check("t1_read_count", 32'(rd_q.size()), 32'd1);
      check("t1_read_addr", 32'(rd_q[0]), 32'd0);
      check("t1_sck_rises", 32'(mosi_q.size()), 32'd8);
      check("t1_mosi_byte", 32'(mosi_byte(0)), 32'hA5);
      check("t1_rx_count", 32'(rx_q.size()), 32'd1);
      check("t1_rxbyte", 32'(rx_q[0]), 32'h3C);
      check("t1_ss_low_cycles", 32'(ss_last), 32'd37);
      check("t1_done_with_ss_rise", 32'(done_at_rise), 32'd1);
      check("t1_done_count", 32'(done_cnt), 32'd1);
      check("t1_busy_after", 32'(a_if.BUSY), 32'd0);

      // Full clamped frame, with a stray START in the middle.
      for (int i = 0; i < 32; i++) begin
         buf_mem[i] = 8'(i);
         sl_mem[i]  = 8'(i) ^ 8'hC6;
      end
      clear_mon();
      pulse_a(6'd40);
      repeat (100) tick();
      pulse_a(6'd5);
      wait_a_done("t2_done_timeout", 1, 2000);
      repeat (4) tick();
      check("t2_read_count", 32'(rd_q.size()), 32'd32);
      bad = 0;
      for (int i = 0; i < rd_q.size(); i++) if (rd_q[i] != 5'(i)) bad++;
      check("t2_addr_sequence_bad", 32'(bad), 32'd0);
      check("t2_sck_rises", 32'(mosi_q.size()), 32'd256);
      bad = 0;
      for (int i = 0; i < 32; i++) if (mosi_byte(i) != 8'(i)) bad++;
      check("t2_mosi_bytes_bad", 32'(bad), 32'd0);
      check("t2_rx_count", 32'(rx_q.size()), 32'd32);
      bad = 0;
      for (int i = 0; i < rx_q.size(); i++) if (rx_q[i] != (8'(i) ^ 8'hC6)) bad++;
      check("t2_rx_bytes_bad", 32'(bad), 32'd0);
      check("t2_done_count", 32'(done_cnt), 32'd1);
      check("t2_ss_low_cycles", 32'(ss_last), 32'(32 * 35 + 2));
      // Each byte starts after 3 gap cycles plus a normal low half-period.
      check("t2_gap_low_runs", 32'(long_n), 32'd32);
      check("t2_bit_low_runs", 32'(short_n), 32'd224);
      check("t2_odd_low_runs", 32'(other_n), 32'd0);

      // START with LEN=0 in IDLE.
      clear_mon();
      pulse_a(6'd0);
      repeat (20) tick();
      check("t3_len0_busy_seen", 32'(busy_seen), 32'd0);
      check("t3_len0_reads", 32'(rd_q.size()), 32'd0);
      check("t3_len0_done", 32'(done_cnt), 32'd0);

      // Reset during the second byte.
      clear_mon();
      pulse_a(6'd3);
      for (k = 0; k < 500; k++) begin
         @(negedge clk);
         #1;
         if (rise_cnt >= 12) break;
      end
      check("t4_reach_byte2", 32'(rise_cnt >= 12), 32'd1);
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("t4_reset_outputs", 32'(out_vec()), 32'(RESET_VEC));
      tick();
      reset = 1'b1;
      repeat (60) tick();
      check("t4_no_done", 32'(done_cnt), 32'd0);
      buf_mem[0] = 8'h5A; buf_mem[1] = 8'hC3;
      sl_mem[0]  = 8'h81; sl_mem[1]  = 8'h7E;
      clear_mon();
      pulse_a(6'd2);
      wait_a_done("t4_done_timeout", 1, 300);
      repeat (2) tick();
      check("t4_read_count", 32'(rd_q.size()), 32'd2);
      check("t4_read_addrs", 32'({rd_q[0], rd_q[1]}), 32'({5'd0, 5'd1}));
      check("t4_mosi_bytes", 32'({mosi_byte(0), mosi_byte(1)}), 32'h5AC3);
      check("t4_rx_bytes", 32'({rx_q[0], rx_q[1]}), 32'h817E);
      check("t4_ss_low_cycles", 32'(ss_last), 32'd72);
      check("t4_done_count", 32'(done_cnt), 32'd1);

      // CLK_DIV=1, back-to-back frames.
      for (int i = 0; i < 32; i++) buf_mem[i] = 8'h11 * 8'(i);
      b_if.LEN   = 6'd3;
      b_if.START = 1'b1;
      tick();
      b_if.START = 1'b0;
      wait_b_done("t5_first_done_timeout", 200);
      b_if.START = 1'b1;
      tick();
      b_if.START = 1'b0;
      wait_b_done("t5_second_done_timeout", 200);
      repeat (3) tick();
      check("t5_done_count", 32'(b_done), 32'd2);
      check("t5_read_count", 32'(b_rd_q.size()), 32'd6);
      bad = 0;
      for (int i = 0; i < b_rd_q.size(); i++) if (b_rd_q[i] != 5'(i % 3)) bad++;
      check("t5_addr_sequence_bad", 32'(bad), 32'd0);
      check("t5_second_frame_addr0", 32'(b_rd_q[3]), 32'd0);
      check("t5_sck_period2", 32'(b_per2), 32'd42);
      check("t5_sck_byte_gaps", 32'(b_perx), 32'd4);
      check("t5_ss_high_gap", 32'((b_hi_last >= 1) && (b_hi_last <= 2)), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/spi_frame_sender.md
Name: spi_frame_sender

Overview:
- Downstream stage of the 32-byte frame buffer in the Serial to SPI bridge.
- On START, it reads LEN bytes from the buffer, address 0 first, using the buffer's ADDR/READ/BYTEOUT read port.
- It shifts each byte out as an SPI mode-0 master, MSB first, under one SS_N assertion.
- It captures MISO bytes in parallel and reports frame completion to the controller.

Parameters:
- CLK_DIV, 4, CLK cycles per SCK half-period; legal range 1..255.
- MAX_LEN, 32, buffer depth in bytes; LEN values above this are clamped.

Ports:
- CLK  input  1  system clock; all logic is on its rising edge.
- RESET  input  1  synchronous, active-low reset.
- START  input  1  frame request; sampled only in IDLE.
- LEN  input  6  number of bytes to send; 0 = ignore START; values above 32 are clamped to 32.
- ADDR  output  5  buffer read address.
- READ  output  1  buffer read strobe; the buffer latches BYTEOUT on its rising edge.
- BYTEIN  input  8  buffer BYTEOUT.
- SCK  output  1  SPI clock; idles low.
- MOSI  output  1  SPI data out.
- MISO  input  1  SPI data in.
- SS_N  output  1  slave select, active low.
- RXBYTE  output  8  last byte received on MISO.
- RXVALID  output  1  one-cycle pulse when RXBYTE updates.
- BUSY  output  1  high from START acceptance until DONE.
- DONE  output  1  one-cycle pulse at frame end.

Behaviour:
- Reset: clock edge with RESET=0 forces:
  - outputs: SS_N=1, SCK=0, MOSI=0, READ=0, ADDR=0, BUSY=0, DONE=0, RXBYTE=0, RXVALID=0;
  - internal: state=IDLE, byte and bit counters cleared.
  - Reset mid-frame aborts immediately; no DONE pulse is issued.
- States: IDLE, FETCH, WAIT, LOAD, SHIFT_LO, SHIFT_HI, FINISH.
- IDLE:
  - START=1 and LEN!=0 at an edge: go to FETCH; BUSY=1, SS_N=0, ADDR=0, READ=1, latch len_r=min(LEN,32).
  - START while BUSY=1 is ignored. START with LEN=0 is ignored: no BUSY, no DONE.
- FETCH (1 cycle): READ=1. Next state WAIT, READ=0.
- WAIT (1 cycle): gives BYTEOUT time to settle after the READ edge. Next state LOAD.
- LOAD (1 cycle): tx_sr<=BYTEIN, MOSI<=BYTEIN[7], bit count=7. Next state SHIFT_LO.
- SHIFT_LO (CLK_DIV cycles): SCK=0, MOSI holds the current bit. On exit, SCK<=1 and MISO is shifted into rx_sr LSB (MSB-first assembly).
- SHIFT_HI (CLK_DIV cycles): SCK=1. On exit, SCK<=0, then:
  - bits remain: present the next bit on MOSI, return to SHIFT_LO;
  - last bit: RXBYTE<=rx_sr (with final bit), RXVALID=1 for one cycle, then
    - more bytes: ADDR<=ADDR+1, READ=1, go to FETCH;
    - last byte: go to FINISH.
- MOSI changes only while SCK is low. MISO is sampled coincident with the SCK rising edge.
- Timing: cycles per byte = 3 + 16*CLK_DIV. SS_N stays low across byte gaps; SCK stays low during gaps.
- FINISH (CLK_DIV cycles): SCK=0, SS_N=0 (hold time). On exit: SS_N=1, DONE=1 for one cycle, BUSY=0, MOSI=0, return to IDLE. START is accepted again from the following edge.
- Address rule: ADDR runs 0..len_r-1 and never wraps. For len_r=32, the last ADDR is 31.
- Simultaneous RXVALID and DONE cannot occur; FINISH separates them by CLK_DIV cycles.

Test Plan:
- Single byte, CLK_DIV=2, buffer[0]=0xA5, START with LEN=1, MISO tied to a model returning 0x3C:
  - exactly one READ pulse at ADDR=0;
  - MOSI bits 1,0,1,0,0,1,0,1 on 8 SCK rising edges;
  - RXBYTE=0x3C with RXVALID pulse;
  - SS_N low for 37 cycles, then DONE.
- Full frame, LEN=40 (clamped), buffer[i]=i:
  - 32 bytes sent, ADDR 0..31;
  - 32 RXVALID pulses, one DONE;
  - SCK low and SS_N low for exactly 3 cycles in each inter-byte gap.
- START pulsed mid-frame and START with LEN=0 in IDLE: no effect; frame timing and DONE count unchanged; BUSY stays low for LEN=0.
- RESET=0 for one cycle during byte 2 bit 4:
  - next edge gives SS_N=1, SCK=0, BUSY=0, no DONE;
  - a new START/LEN=2 sends buffer[0], buffer[1] correctly.
- CLK_DIV=1, LEN=3, back-to-back START the cycle after DONE:
  - SCK period is 2 CLK cycles;
  - second frame starts with READ at ADDR=0;
  - SS_N high for at least 1 cycle between frames.
